// File: rtl/vga_pkg.sv
// Shared types and default 640x480 geometry for the VGA rectangle animator.
package vga_pkg;

  localparam int unsigned VGA_H_VISIBLE    = 640;
  localparam int unsigned VGA_V_VISIBLE    = 480;
  localparam int unsigned VGA_PIXEL_BITS   = 11;

  // Animator sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP_X = 2'd1,
    ST_STEP_Y = 2'd2,
    ST_COMMIT = 2'd3
  } anim_state_e;

  // Per-axis travel direction
  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_e;

endpackage

// File: rtl/vga_axis_bouncer.sv
// One axis of rectangle motion: shadow position, direction and bounce flag.
// A load overrides stepping and leaves the direction untouched.
module vga_axis_bouncer
  import vga_pkg::*;
#(
  parameter int W    = 11,
  parameter int STEP = 2,
  parameter int MAX  = 576,
  parameter int INIT = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         step_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] pos_o,
  output logic         bounce_o
);

  // One extra bit so pos+STEP can never wrap before the limit compare.
  localparam logic [W:0] STEP_EXT = (W+1)'(STEP);
  localparam logic [W:0] MAX_EXT  = (W+1)'(MAX);

  logic [W-1:0] pos_q, pos_d;
  dir_e         dir_q, dir_d;
  logic         bounce_q, bounce_d;
  logic [W:0]   pos_ext;
  logic [W:0]   sum;
  logic [W:0]   diff;

  // Next position/direction: load, or step with reflection at 0 and MAX.
  always_comb begin
    pos_d    = pos_q;
    dir_d    = dir_q;
    bounce_d = bounce_q;
    pos_ext  = {1'b0, pos_q};
    sum      = pos_ext + STEP_EXT;
    diff     = pos_ext - STEP_EXT;
    if (load_i) begin
      pos_d    = load_val_i;
      bounce_d = 1'b0;
    end else if (step_i) begin
      bounce_d = 1'b0;
      if (dir_q == DIR_INC) begin
        if (sum >= MAX_EXT) begin
          pos_d    = MAX_EXT[W-1:0];
          dir_d    = DIR_DEC;
          bounce_d = 1'b1;
        end else begin
          pos_d = sum[W-1:0];
        end
      end else begin
        if (pos_ext <= STEP_EXT) begin
          pos_d    = '0;
          dir_d    = DIR_INC;
          bounce_d = 1'b1;
        end else begin
          pos_d = diff[W-1:0];
        end
      end
    end
  end

  // Axis state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pos_q    <= W'(INIT);
      dir_q    <= DIR_INC;
      bounce_q <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      bounce_q <= bounce_d;
    end
  end

  assign pos_o    = pos_q;
  assign bounce_o = bounce_q;

endmodule

// File: rtl/vga_rect_animator.sv
// Frame-synchronous bouncing-rectangle controller. Steps the rectangle once
// per frame at vblank start and only updates renderer inputs in COMMIT.
// Optional host position write port: define VGA_RECT_ANIM_WRITE_EN.
module vga_rect_animator
  import vga_pkg::*;
#(
  parameter int WIDTH_VISIBLE  = VGA_H_VISIBLE,
  parameter int HEIGHT_VISIBLE = VGA_V_VISIBLE,
  parameter int PIXEL_BITWIDTH = VGA_PIXEL_BITS,
  parameter int RECT_WIDTH     = 64,
  parameter int RECT_HEIGHT    = 48,
  parameter int INIT_X         = 0,
  parameter int INIT_Y         = 0,
  parameter int STEP_X         = 2,
  parameter int STEP_Y         = 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [PIXEL_BITWIDTH-1:0] i_vga_x,
  input  logic [PIXEL_BITWIDTH-1:0] i_vga_y,
  input  logic                      i_enable,
`ifdef VGA_RECT_ANIM_WRITE_EN
  input  logic                      i_wr_valid,
  output logic                      o_wr_ready,
  input  logic [PIXEL_BITWIDTH-1:0] i_wr_x,
  input  logic [PIXEL_BITWIDTH-1:0] i_wr_y,
`endif
  output logic [PIXEL_BITWIDTH-1:0] o_rect_x,
  output logic [PIXEL_BITWIDTH-1:0] o_rect_y,
  output logic [PIXEL_BITWIDTH-1:0] o_rect_width,
  output logic [PIXEL_BITWIDTH-1:0] o_rect_height,
  output logic                      o_frame_tick,
  output logic                      o_busy,
  output logic                      o_bounce_x,
  output logic                      o_bounce_y
);

  localparam int PB = PIXEL_BITWIDTH;
  localparam logic [PB-1:0] MAX_X = PB'(WIDTH_VISIBLE - RECT_WIDTH);
  localparam logic [PB-1:0] MAX_Y = PB'(HEIGHT_VISIBLE - RECT_HEIGHT);

  anim_state_e   state_q, state_d;
  logic          match, match_q, trigger;
  logic          pend;
  logic [PB-1:0] wr_x, wr_y;
  logic [PB-1:0] pos_x, pos_y;
  logic          bnc_x, bnc_y;
  logic [PB-1:0] rect_x_q, rect_y_q;
  logic          tick_q, busy_q, bounce_x_q, bounce_y_q;

  // First blank line, first pixel: happens once per frame; edge-detected for safety.
  assign match   = (i_vga_x == '0) && (i_vga_y == PB'(HEIGHT_VISIBLE));
  assign trigger = match && !match_q;

`ifdef VGA_RECT_ANIM_WRITE_EN
  logic          pend_q;
  logic [PB-1:0] wr_x_q, wr_y_q;

  // Trigger has priority over a host write; the write is held off until IDLE.
  assign o_wr_ready = (state_q == ST_IDLE) && !trigger && !pend_q;

  // Capture (clamped) host position; consumed by the next frame's COMMIT.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pend_q <= 1'b0;
      wr_x_q <= '0;
      wr_y_q <= '0;
    end else if (state_q == ST_COMMIT) begin
      pend_q <= 1'b0;
    end else if (i_wr_valid && o_wr_ready) begin
      pend_q <= 1'b1;
      wr_x_q <= (i_wr_x > MAX_X) ? MAX_X : i_wr_x;
      wr_y_q <= (i_wr_y > MAX_Y) ? MAX_Y : i_wr_y;
    end
  end

  assign pend = pend_q;
  assign wr_x = wr_x_q;
  assign wr_y = wr_y_q;
`else
  assign pend = 1'b0;
  assign wr_x = '0;
  assign wr_y = '0;
`endif

  vga_axis_bouncer #(
    .W(PB), .STEP(STEP_X), .MAX(WIDTH_VISIBLE - RECT_WIDTH), .INIT(INIT_X)
  ) u_axis_x (
    .clk_i      (i_clk),
    .rst_i      (i_reset),
    .step_i     ((state_q == ST_STEP_X) && !pend),
    .load_i     ((state_q == ST_STEP_X) && pend),
    .load_val_i (wr_x),
    .pos_o      (pos_x),
    .bounce_o   (bnc_x)
  );

  vga_axis_bouncer #(
    .W(PB), .STEP(STEP_Y), .MAX(HEIGHT_VISIBLE - RECT_HEIGHT), .INIT(INIT_Y)
  ) u_axis_y (
    .clk_i      (i_clk),
    .rst_i      (i_reset),
    .step_i     ((state_q == ST_STEP_Y) && !pend),
    .load_i     ((state_q == ST_STEP_Y) && pend),
    .load_val_i (wr_y),
    .pos_o      (pos_y),
    .bounce_o   (bnc_y)
  );

  // Next-state: leave IDLE on a frame trigger when there is work to do.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (trigger && (i_enable || pend)) state_d = ST_STEP_X;
      ST_STEP_X: state_d = ST_STEP_Y;
      ST_STEP_Y: state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register and match history.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match;
    end
  end

  // Registered outputs; rectangle and bounce flags move only out of COMMIT.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rect_x_q   <= PB'(INIT_X);
      rect_y_q   <= PB'(INIT_Y);
      tick_q     <= 1'b0;
      busy_q     <= 1'b0;
      bounce_x_q <= 1'b0;
      bounce_y_q <= 1'b0;
    end else begin
      tick_q     <= trigger;
      busy_q     <= (state_q != ST_IDLE);
      bounce_x_q <= 1'b0;
      bounce_y_q <= 1'b0;
      if (state_q == ST_COMMIT) begin
        rect_x_q   <= pos_x;
        rect_y_q   <= pos_y;
        bounce_x_q <= bnc_x;
        bounce_y_q <= bnc_y;
      end
    end
  end

  assign o_rect_x      = rect_x_q;
  assign o_rect_y      = rect_y_q;
  assign o_rect_width  = PB'(RECT_WIDTH);
  assign o_rect_height = PB'(RECT_HEIGHT);
  assign o_frame_tick  = tick_q;
  assign o_busy        = busy_q;
  assign o_bounce_x    = bounce_x_q;
  assign o_bounce_y    = bounce_y_q;

endmodule

// File: tb/tb_vga_rect_animator.sv
// Scoreboard bench for vga_rect_animator: stimulus pushes the expected
// commit per frame; a monitor pops on each o_frame_tick and checks the
// busy window and the committed rectangle/bounce pulses.
module tb_vga_rect_animator;

  localparam int PB    = 11;
  localparam int MAXX  = 576;
  localparam int MAXY  = 432;

  logic          clk = 1'b0;
  logic          rst;
  logic [PB-1:0] vga_x, vga_y;
  logic          enable;
  logic [PB-1:0] rect_x, rect_y, rect_w, rect_h;
  logic          tick, busy, bx, by;
`ifdef VGA_RECT_ANIM_WRITE_EN
  logic          wr_valid;
  logic          wr_ready;
  logic [PB-1:0] wr_x, wr_y;
`endif

  always #5 clk = ~clk;

  vga_rect_animator dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_vga_x       (vga_x),
    .i_vga_y       (vga_y),
    .i_enable      (enable),
`ifdef VGA_RECT_ANIM_WRITE_EN
    .i_wr_valid    (wr_valid),
    .o_wr_ready    (wr_ready),
    .i_wr_x        (wr_x),
    .i_wr_y        (wr_y),
`endif
    .o_rect_x      (rect_x),
    .o_rect_y      (rect_y),
    .o_rect_width  (rect_w),
    .o_rect_height (rect_h),
    .o_frame_tick  (tick),
    .o_busy        (busy),
    .o_bounce_x    (bx),
    .o_bounce_y    (by)
  );

  typedef struct {
    int x;
    int y;
    bit bx;
    bit by;
    bit moved;
    bit abort;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ticks_seen = 0;
  int   ticks_exp = 0;
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input int x, input int y, input bit ebx, input bit eby,
                      input bit moved, input bit abort);
    exp_t e;
    e.x = x; e.y = y; e.bx = ebx; e.by = eby; e.moved = moved; e.abort = abort;
    sb.push_back(e);
    ticks_exp++;
  endtask

  // Reflection path in closed form: a triangle wave of period 2*MAX per axis.
  function automatic void model(input int k, output int x, output int y,
                                output bit ebx, output bit eby);
    int tx, ty;
    tx = (2 * k) % (2 * MAXX);
    ty = k % (2 * MAXY);
    x = (tx <= MAXX) ? tx : (2 * MAXX - tx);
    y = (ty <= MAXY) ? ty : (2 * MAXY - ty);
    ebx = (x == MAXX) || (x == 0);
    eby = (y == MAXY) || (y == 0);
  endfunction

  task automatic run_frame(input bit en);
    @(posedge clk); #1;
    enable = en;
    vga_x  = '0;
    vga_y  = 11'd480;
    @(posedge clk); #1;
    vga_x  = 11'd5;
    vga_y  = 11'd100;
    repeat (5) @(posedge clk);
  endtask

`ifdef VGA_RECT_ANIM_WRITE_EN
  task automatic host_write(input int x, input int y);
    int n;
    @(posedge clk); #1;
    wr_valid = 1'b1;
    wr_x = PB'(x);
    wr_y = PB'(y);
    n = 0;
    #3;
    while (!wr_ready && n < 20) begin
      n++;
      @(posedge clk); #4;
    end
    chk("wr_accept_in_budget", (n < 20), 1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  // Write presented in the same cycle as the vblank match: trigger must win.
  task automatic frame_with_write(input int x, input int y);
    int n;
    @(posedge clk); #1;
    enable   = 1'b1;
    vga_x    = '0;
    vga_y    = 11'd480;
    wr_valid = 1'b1;
    wr_x     = PB'(x);
    wr_y     = PB'(y);
    #3;
    chk("wr_ready_at_trigger", wr_ready, 0);
    @(posedge clk); #1;
    vga_x = 11'd5;
    vga_y = 11'd100;
    n = 0;
    #3;
    while (!wr_ready && n < 20) begin
      n++;
      @(posedge clk); #4;
    end
    chk("wr_ready_low_cycles", n, 3);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    repeat (3) @(posedge clk);
  endtask
`endif

  // Monitor: each frame tick pops one expected commit.
  initial begin
    forever begin
      @(negedge clk);
      if (tick === 1'b1) begin
        ticks_seen++;
        if (sb.size() == 0) begin
          chk("tick_unexpected", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          if (!mon_e.abort) begin
            chk("busy_at_tick", busy, 0);
            for (int k = 0; k < 3; k++) begin
              @(negedge clk);
              chk("busy_window", busy, mon_e.moved);
            end
            chk("rect_x", rect_x, mon_e.x);
            chk("rect_y", rect_y, mon_e.y);
            chk("bounce_x", bx, mon_e.bx);
            chk("bounce_y", by, mon_e.by);
            chk("tick_one_cycle", tick, 0);
            @(negedge clk);
            chk("bounce_x_clear", bx, 0);
            chk("bounce_y_clear", by, 0);
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ex, ey;
    bit ebx, eby;
    rst    = 1'b1;
    enable = 1'b0;
    vga_x  = 11'd5;
    vga_y  = 11'd100;
`ifdef VGA_RECT_ANIM_WRITE_EN
    wr_valid = 1'b0;
    wr_x     = '0;
    wr_y     = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    chk("reset_rect_x", rect_x, 0);
    chk("reset_rect_y", rect_y, 0);
    chk("reset_width", rect_w, 64);
    chk("reset_height", rect_h, 48);
    chk("reset_tick", tick, 0);
    chk("reset_busy", busy, 0);
    chk("reset_bounce_x", bx, 0);
    chk("reset_bounce_y", by, 0);
`ifdef VGA_RECT_ANIM_WRITE_EN
    chk("reset_wr_ready", wr_ready, 1);
`endif

    // Long run through right, bottom, left and top reflections.
    // Frame 1728 lands both axes on 0 together; 1730 ends at (4,2).
    for (int k = 1; k <= 1730; k++) begin
      model(k, ex, ey, ebx, eby);
      push(ex, ey, ebx, eby, 1'b1, 1'b0);
      run_frame(1'b1);
    end

    // Motion disabled: ticks continue, nothing moves, FSM stays idle.
    for (int k = 0; k < 3; k++) begin
      push(4, 2, 1'b0, 1'b0, 1'b0, 1'b0);
      run_frame(1'b0);
    end

    // Asynchronous reset while in STEP_Y.
    push(0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    enable = 1'b1;
    vga_x  = '0;
    vga_y  = 11'd480;
    @(posedge clk); #1;
    vga_x  = 11'd5;
    vga_y  = 11'd100;
    @(posedge clk); #1;
    chk("busy_before_reset", busy, 1);
    chk("rect_x_before_reset", rect_x, 4);
    #1;
    rst = 1'b1;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_rect_x", rect_x, 0);
    chk("midreset_rect_y", rect_y, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);

    push(2, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(1'b1);

`ifdef VGA_RECT_ANIM_WRITE_EN
    // Write lands as-is, then the next frames step and reflect from it.
    host_write(575, 431);
    push(575, 431, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(1'b1);
    push(576, 432, 1'b1, 1'b1, 1'b1, 1'b0);
    run_frame(1'b1);
    push(574, 431, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(1'b1);
    // Both axes now decreasing; a write keeps that direction.
    host_write(1, 1);
    push(1, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(1'b0);
    push(0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    run_frame(1'b1);
    // Write held through a trigger, then clamped x and committed with no step.
    push(2, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    frame_with_write(1000, 5);
    push(576, 5, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(1'b0);
`endif

    repeat (10) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    chk("tick_count", ticks_seen, ticks_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
